// File: rtl/hp_dma_pkg.sv
// ---------------------------------------------------------------------------
// hp_dma_pkg
// Shared AXI3 constants, the write-DMA FSM state type and a beat-size helper
// for the HP0 write DMA (hp_wr_dma) and its channel FIFO (hp_wr_fifo).
// ---------------------------------------------------------------------------
package hp_dma_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_AW   = 3'd2,
      ST_W    = 3'd3,
      ST_B    = 3'd4
   } dma_state_t;

   // bytes carried by one data beat of width dw
   function automatic int beat_bytes(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/hp_wr_fifo.sv
// ---------------------------------------------------------------------------
// hp_wr_fifo
// Synchronous first-word-fall-through FIFO: dout always shows the head word
// while empty is low. clr empties the FIFO in one cycle.
// Ports: clk, rst (async, active high), clr, push/din, pop/dout,
//        full, empty, count (0..DEPTH).
// Push while full and pop while empty are ignored.
// ---------------------------------------------------------------------------
module hp_wr_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic [DW-1:0]          din,
   input  logic                   pop,
   output logic [DW-1:0]          dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic          do_push, do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clr) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + PW'(1);
         if (do_pop)  rp <= rp + PW'(1);
         // push and pop together leave the count unchanged
         if (do_push && !do_pop)      count <= count + (PW+1)'(1);
         else if (!do_push && do_pop) count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/hp_wr_dma.sv
// ---------------------------------------------------------------------------
// hp_wr_dma
// Multi-channel write DMA into PS DDR over the AXI3 S_AXI_HP0 port. Each
// channel stream is buffered in its own FWFT FIFO and written as fixed-length
// INCR bursts into a per-channel ring buffer. A round-robin arbiter picks the
// next channel holding at least BURST words; one transaction is in flight
// at a time (AW, then W, then B).
// Ports:
//   SYS_CLK, SYS_RST (async, active high)
//   CFG_EN, CFG_BASE[NCH*AW], CFG_SIZE[NCH*AW]  ring configuration
//   CH_VALID/CH_READY/CH_DATA                   per-channel input streams
//   WR_PTR[NCH*AW]                              committed ring byte offsets
//   ERR                                         sticky non-OKAY BRESP flag
//   AW*/W*/B*                                   AXI3 write master to HP0
// Optional: define HPDMA_WRAP_IRQ_EN to add WRAP_IRQ[NCH], a one-cycle pulse
// when a channel's WR_PTR wraps to 0.
// ---------------------------------------------------------------------------
module hp_wr_dma
   import hp_dma_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int DW         = 32,
   parameter int BURST      = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int AW         = 32
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST,
   input  logic              CFG_EN,
   input  logic [NCH*AW-1:0] CFG_BASE,
   input  logic [NCH*AW-1:0] CFG_SIZE,
   input  logic [NCH-1:0]    CH_VALID,
   output logic [NCH-1:0]    CH_READY,
   input  logic [NCH*DW-1:0] CH_DATA,
   output logic [NCH*AW-1:0] WR_PTR,
   output logic              ERR,
   output logic [AW-1:0]     AWADDR,
   output logic [3:0]        AWLEN,
   output logic [2:0]        AWSIZE,
   output logic [1:0]        AWBURST,
   output logic [5:0]        AWID,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DW-1:0]     WDATA,
   output logic [DW/8-1:0]   WSTRB,
   output logic [5:0]        WID,
   output logic              WLAST,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [5:0]        BID,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY
`ifdef HPDMA_WRAP_IRQ_EN
   ,
   output logic [NCH-1:0]    WRAP_IRQ
`endif
);
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AW-1:0] BURST_BYTES = AW'(BURST * beat_bytes(DW));

   dma_state_t                 state;
   logic [GW-1:0]              g, last_g, grant;
   logic [4:0]                 beat;
   logic [NCH-1:0]             elig, full, empty, push, pop;
   logic [NCH-1:0][DW-1:0]     dout;
   logic [NCH-1:0][CW-1:0]     count;
   logic [NCH-1:0][AW-1:0]     wr_ptr, base, size;
   logic [AW-1:0]              ptr_sum;
   logic                       flush, wrap_now, unused_ok;

   assign base   = CFG_BASE;
   assign size   = CFG_SIZE;
   assign WR_PTR = wr_ptr;
   // flushing only happens between bursts, never under an active transfer
   assign flush  = (state == ST_IDLE) && !CFG_EN;

   genvar i;
   generate
      for (i = 0; i < NCH; i++) begin : g_ch
         assign CH_READY[i] = CFG_EN & ~full[i];
         assign push[i]     = CH_VALID[i] & CH_READY[i];
         assign pop[i]      = (state == ST_W) && (g == GW'(i)) && WREADY && !empty[i];
         assign elig[i]     = (count[i] >= CW'(BURST));

         hp_wr_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (SYS_CLK),
            .rst   (SYS_RST),
            .clr   (flush),
            .push  (push[i]),
            .din   (CH_DATA[i*DW +: DW]),
            .pop   (pop[i]),
            .dout  (dout[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
         );
      end
   endgenerate

   // Round robin: scan downwards so the final assignment is the eligible
   // channel closest after the last grant.
   always_comb begin
      int idx;
      idx   = 0;
      grant = last_g;
      for (int k = NCH; k >= 1; k--) begin
         idx = int'(last_g) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (elig[idx]) grant = GW'(idx);
      end
   end

   assign AWLEN   = 4'(BURST - 1);
   assign AWSIZE  = AXI_SIZE_4B;
   assign AWBURST = AXI_BURST_INCR;
   assign WSTRB   = '1;
   assign AWID    = 6'(g);
   assign WID     = 6'(g);
   assign AWVALID = (state == ST_AW);
   assign WVALID  = (state == ST_W) && !empty[g];
   assign WDATA   = WVALID ? dout[g] : '0;
   assign WLAST   = (state == ST_W) && (beat == 5'(BURST - 1));
   assign BREADY  = (state == ST_B);

   assign ptr_sum  = wr_ptr[g] + BURST_BYTES;
   assign wrap_now = (state == ST_B) && BVALID && (ptr_sum == size[g]);

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state  <= ST_IDLE;
         g      <= '0;
         last_g <= GW'(NCH - 1);   // first scan starts at channel 0
         beat   <= '0;
         AWADDR <= '0;
         wr_ptr <= '0;
         ERR    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!CFG_EN)    wr_ptr <= '0;
               else if (|elig) state  <= ST_ARB;
            end
            ST_ARB: begin
               g      <= grant;
               last_g <= grant;
               AWADDR <= base[grant] + wr_ptr[grant];
               state  <= ST_AW;
            end
            ST_AW: begin
               beat <= '0;
               if (AWREADY) state <= ST_W;
            end
            ST_W: begin
               if (WVALID && WREADY) begin
                  beat <= beat + 5'd1;
                  if (WLAST) state <= ST_B;
               end
            end
            ST_B: begin
               if (BVALID) begin
                  wr_ptr[g] <= wrap_now ? '0 : ptr_sum;
                  if (BRESP != AXI_RESP_OKAY) ERR <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef HPDMA_WRAP_IRQ_EN
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         WRAP_IRQ <= '0;
      end else begin
         WRAP_IRQ <= '0;
         if (wrap_now) WRAP_IRQ[g] <= 1'b1;
      end
   end
`endif

   // the single-outstanding master never needs the response ID
   assign unused_ok = ^BID;

endmodule

// File: tb/tb_hp_wr_dma.sv
module tb_hp_wr_dma;
   logic        clk = 1'b0;
   logic        rst;
   logic        CFG_EN;
   logic [63:0] CFG_BASE, CFG_SIZE;
   logic [1:0]  CH_VALID, CH_READY;
   logic [63:0] CH_DATA;
   logic [63:0] WR_PTR;
   logic        ERR;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic [5:0]  AWID;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic [5:0]  WID;
   logic        WLAST, WVALID, WREADY;
   logic [5:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
`ifdef HPDMA_WRAP_IRQ_EN
   logic [1:0]  WRAP_IRQ;
`endif

   always #5 clk = ~clk;

   hp_wr_dma #(.NCH(2), .DW(32), .BURST(16), .FIFO_DEPTH(64), .AW(32)) dut (
      .SYS_CLK(clk), .SYS_RST(rst), .CFG_EN(CFG_EN),
      .CFG_BASE(CFG_BASE), .CFG_SIZE(CFG_SIZE),
      .CH_VALID(CH_VALID), .CH_READY(CH_READY), .CH_DATA(CH_DATA),
      .WR_PTR(WR_PTR), .ERR(ERR),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WID(WID), .WLAST(WLAST),
      .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef HPDMA_WRAP_IRQ_EN
      , .WRAP_IRQ(WRAP_IRQ)
`endif
   );

   // ring configuration mirrored for the reference model
   logic [31:0] base_m [2];
   logic [31:0] size_m [2];

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] exp_q [2][$];
   logic [31:0] exp_ptr [2];
   logic        exp_err;
   logic [1:0]  irq_exp;
   int          to_send [2];
   int          tot_acc [2];
   int          irq_seen [2];
   bit          cmp_ptr_en;

   // AXI slave / monitor state
   int          cur_id, beat, burst_beats, b_count, err_burst;
   bit          in_w, b_pend, b_prev, tog, aw_hold, rnd_gap;
   int          b_prev_id, aw_wait, aw_delay, wr_mode, cyc;
   int          acc_edge, aw_edge;
   int          aw_ids [$];
   logic [31:0] aw_addrs [$];
   logic [31:0] ptr_log [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave, source driver and scoreboard. Drives on the falling edge and
   // samples 1 time unit later; whatever is sampled as valid&ready becomes a
   // handshake at the following rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         AWREADY = !aw_hold && (aw_wait >= aw_delay);
         tog     = !tog;
         WREADY  = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? tog : 1'($urandom_range(0, 1));
         BVALID  = b_pend;
         BID     = 6'(cur_id);
         BRESP   = (b_count + 1 == err_burst) ? 2'b10 : 2'b00;
         for (int i = 0; i < 2; i++) begin
            CH_VALID[i]        = (to_send[i] > 0) && (!rnd_gap || $urandom_range(0, 3) != 0);
            CH_DATA[i*32 +: 32] = $urandom;
         end
         #1;
         cyc++;
         chk("err", ERR, exp_err);
         if (b_prev) ptr_log.push_back(WR_PTR[b_prev_id*32 +: 32]);
         b_prev = 0;
         if (cmp_ptr_en)
            for (int i = 0; i < 2; i++) chk("wr_ptr", WR_PTR[i*32 +: 32], exp_ptr[i]);
`ifdef HPDMA_WRAP_IRQ_EN
         chk("wrap_irq", WRAP_IRQ, irq_exp);
         for (int i = 0; i < 2; i++) irq_seen[i] += int'(WRAP_IRQ[i]);
`endif
         irq_exp = '0;
         if (in_w) chk("wvalid_hold", WVALID, 1);
         // input acceptance
         for (int i = 0; i < 2; i++) begin
            if (CH_VALID[i] && CH_READY[i]) begin
               exp_q[i].push_back(CH_DATA[i*32 +: 32]);
               to_send[i]--;
               tot_acc[i]++;
               if (i == 0 && tot_acc[0] == 16) acc_edge = cyc;
            end
         end
         // write data
         if (WVALID && WREADY) begin
            chk("w_in_burst", in_w, 1);
            chk("w_underrun", exp_q[cur_id].size() > 0, 1);
            if (exp_q[cur_id].size() > 0) chk("wdata", WDATA, exp_q[cur_id].pop_front());
            chk("wlast", WLAST, beat == 15);
            chk("wid", WID, cur_id);
            beat++;
            if (WLAST) begin
               burst_beats = beat;
               beat   = 0;
               in_w   = 0;
               b_pend = 1;
            end
         end
         // write address
         if (AWVALID && aw_edge < 0) aw_edge = cyc - 1;
         if (AWVALID && AWREADY) begin
            chk("one_outstanding", in_w | b_pend, 0);
            chk("awid_range", AWID < 2, 1);
            cur_id = (AWID < 2) ? int'(AWID) : 0;
            chk("awaddr", AWADDR, base_m[cur_id] + exp_ptr[cur_id]);
            aw_ids.push_back(cur_id);
            aw_addrs.push_back(AWADDR);
            in_w    = 1;
            aw_wait = 0;
         end else if (AWVALID) begin
            aw_wait++;
         end
         // write response: ring offset advances by one burst of 64 bytes
         if (BVALID && BREADY) begin
            logic [31:0] np;
            np = exp_ptr[cur_id] + 32'h40;
            if (np == size_m[cur_id]) begin
               np = 0;
               irq_exp[cur_id] = 1'b1;
            end
            exp_ptr[cur_id] = np;
            if (BRESP != 2'b00) exp_err = 1'b1;
            b_prev    = 1;
            b_prev_id = cur_id;
            b_pend    = 0;
            b_count++;
         end
      end
   end

   task automatic wait_b(input int tgt);
      int t;
      t = 0;
      while (b_count < tgt && t < 5000) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
      #2;
      chk("burst_count", b_count, tgt);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t, na, nb;
      logic [31:0] p0;
      logic [31:0] a1_tab [4];
      logic [31:0] p1_tab [4];
      int          id2_tab [6];
      a1_tab  = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0000, 32'h1000_0040};
      p1_tab  = '{32'h40, 32'h0, 32'h40, 32'h0};
      id2_tab = '{0, 1, 0, 1, 0, 1};
      base_m = '{32'h1000_0000, 32'h2000_0000};
      size_m = '{32'h80, 32'h100};
      CFG_BASE = {base_m[1], base_m[0]};
      CFG_SIZE = {size_m[1], size_m[0]};
      rst = 1; CFG_EN = 0; CH_VALID = '0; CH_DATA = '0;
      AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
      exp_ptr = '{0, 0}; exp_err = 0; irq_exp = '0; to_send = '{0, 0};
      tot_acc = '{0, 0}; irq_seen = '{0, 0}; cmp_ptr_en = 1;
      cur_id = 0; beat = 0; burst_beats = 0; b_count = 0; err_burst = -1;
      in_w = 0; b_pend = 0; b_prev = 0; tog = 0; aw_hold = 0; rnd_gap = 0;
      b_prev_id = 0; aw_wait = 0; aw_delay = 0; wr_mode = 0; cyc = 0;
      acc_edge = -1; aw_edge = -1;

      // reset state
      repeat (3) @(negedge clk);
      #2;
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_wlast", WLAST, 0);
      chk("rst_bready", BREADY, 0);
      chk("rst_err", ERR, 0);
      chk("rst_wr_ptr", WR_PTR, 0);
      chk("rst_awaddr", AWADDR, 0);
      chk("rst_wdata", WDATA, 0);
      chk("rst_ch_ready", CH_READY, 0);
      chk("awlen", AWLEN, 15);
      chk("awsize", AWSIZE, 2);
      chk("awburst", AWBURST, 1);
      chk("wstrb", WSTRB, 4'hf);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      #2;
      chk("dis_ch_ready", CH_READY, 0);
      CFG_EN = 1;
      @(negedge clk);
      #2;
      chk("en_ch_ready", CH_READY, 2'b11);

      // 64 words on ch0: four bursts walking the 0x80 ring twice
      to_send[0] = 64;
      wait_b(4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_awaddr", aw_addrs[i], a1_tab[i]);
         chk("t1_wr_ptr", ptr_log[i], p1_tab[i]);
      end
      chk("t1_latency", aw_edge - acc_edge, 2);
`ifdef HPDMA_WRAP_IRQ_EN
      chk("t1_irq_pulses", irq_seen[0], 2);
`endif
      aw_ids.delete(); aw_addrs.delete(); ptr_log.delete();

      // both channels loaded, ch0 a little ahead: strict alternation
      t0 = b_count;
      to_send[0] = 48;
      repeat (4) @(negedge clk);
      to_send[1] = 48;
      wait_b(t0 + 6);
      for (int i = 0; i < 6; i++) chk("t2_awid", aw_ids[i], id2_tab[i]);
      aw_ids.delete(); aw_addrs.delete(); ptr_log.delete();

      // WREADY toggling, AWREADY 5 cycles late
      t0 = b_count;
      wr_mode = 1; aw_delay = 5;
      to_send[0] = 32;
      wait_b(t0 + 2);
      chk("t3_idle_aw", AWVALID, 0);
      chk("t3_idle_w", WVALID, 0);
      chk("t3_idle_b", BREADY, 0);
      wr_mode = 0; aw_delay = 0;

      // full FIFO with AW stalled
      t0 = b_count;
      aw_hold = 1;
      to_send[0] = 70;
      repeat (100) @(negedge clk);
      #2;
      chk("t5_accepted", exp_q[0].size(), 64);
      chk("t5_ready_low", CH_READY[0], 0);
      chk("t5_left", to_send[0], 6);
      to_send[0] = 0;
      aw_hold = 0;
      wait_b(t0 + 4);
      chk("t5_drained", exp_q[0].size(), 0);

      // randomized rounds: gapped sources, random WREADY
      wr_mode = 2; rnd_gap = 1;
      for (int r = 0; r < 3; r++) begin
         t0 = b_count;
         na = 16 * $urandom_range(1, 3);
         nb = 16 * $urandom_range(1, 3);
         to_send[0] = na;
         to_send[1] = nb;
         wait_b(t0 + (na + nb) / 16);
         chk("rnd_drained", exp_q[0].size() + exp_q[1].size(), 0);
      end
      wr_mode = 0; rnd_gap = 0;
      ptr_log.delete();

      // SLVERR on the second burst: ERR sticks, pointer still advances
      t0 = b_count;
      p0 = exp_ptr[0];
      err_burst = t0 + 2;
      to_send[0] = 48;
      wait_b(t0 + 1);
      chk("t4_err_before", ERR, 0);
      wait_b(t0 + 3);
      chk("t4_err_set", ERR, 1);
      for (int i = 0; i < 3; i++)
         chk("t4_wr_ptr", ptr_log[i], (p0 + 32'h40 * (i + 1)) % 32'h80);
      repeat (20) @(negedge clk);
      #2;
      chk("t4_err_sticky", ERR, 1);

      // CFG_EN drops at beat 5: burst completes, then flush
      t0 = b_count;
      to_send[0] = 20;
      t = 0;
      while (!(in_w && beat == 5) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      CFG_EN = 0;
      cmp_ptr_en = 0;
      to_send[0] = 0;
      #2;
      chk("t6_ready_drop", CH_READY, 0);
      wait_b(t0 + 1);
      chk("t6_beats", burst_beats, 16);
      chk("t6_wr_ptr", WR_PTR, 0);
      chk("t6_ch_ready", CH_READY, 0);
      chk("t6_awvalid", AWVALID, 0);
      exp_q[0].delete();
      exp_ptr = '{0, 0};
      cmp_ptr_en = 1;
      @(negedge clk);
      CFG_EN = 1;
      to_send[0] = 12;   // stale words left in the FIFO would complete a burst
      repeat (40) @(negedge clk);
      #2;
      chk("t6_flushed", b_count, t0 + 1);
      to_send[0] = 4;
      wait_b(t0 + 2);
      chk("t6_after", exp_q[0].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
